// File: rtl/uart_instruction_assembler_pkg.sv
// Shared types and constants for the UART-to-instruction byte assembler.
package uart_instruction_assembler_pkg;

  localparam int INSTR_W         = 32;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_INSTR = 4;
  localparam int IDX_W           = 2;
  localparam int COUNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  // Places byte number idx into its lane; big-endian mirrors the lane index.
  function automatic logic [INSTR_W-1:0] insert_byte(
    input logic [INSTR_W-1:0] word,
    input logic [IDX_W-1:0]   idx,
    input logic [BYTE_W-1:0]  data,
    input logic               little_endian
  );
    logic [INSTR_W-1:0] res;
    logic [IDX_W-1:0]   lane;
    logic [4:0]         base;
    res  = word;
    lane = little_endian ? idx : ~idx;
    base = {lane, 3'b000};
    res[base +: BYTE_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/uart_instruction_assembler_if.sv
// Byte-in / instruction-out bundle. rx_valid and data_received are one-cycle
// strobes with no back-pressure: a strobe means the data bus is valid in that cycle.
interface uart_instruction_assembler_if;
  import uart_instruction_assembler_pkg::*;

  logic [BYTE_W-1:0]  i_rx_byte;
  logic               i_rx_valid;
  logic               i_clear;
  logic [INSTR_W-1:0] o_instruction;
  logic               o_data_received;
  logic [COUNT_W-1:0] o_word_count;
  logic               o_busy;
  logic               o_timeout_err;
  logic               o_overflow_err;
  logic               o_debug_flag;
  state_t             dbg_state;

  modport master (
    output i_rx_byte, i_rx_valid, i_clear,
    input  o_instruction, o_data_received, o_word_count, o_busy,
           o_timeout_err, o_overflow_err, o_debug_flag, dbg_state
  );

  modport slave (
    input  i_rx_byte, i_rx_valid, i_clear,
    output o_instruction, o_data_received, o_word_count, o_busy,
           o_timeout_err, o_overflow_err, o_debug_flag, dbg_state
  );
endinterface

// File: rtl/uart_instruction_assembler_byte_timeout_counter.sv
// Inter-byte idle counter: counts while enabled, pulses expired on its last
// count and wraps; restart or disable returns it to zero.
module uart_instruction_assembler_byte_timeout_counter #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (restart || !enable || (count_q == LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && !restart && (count_q == LAST);
endmodule

// File: rtl/uart_instruction_assembler.sv
// Packs UART RX bytes into 32-bit instruction words, strobing each finished
// word once, and stops accepting after MAX_WORDS until cleared.
module uart_instruction_assembler
  import uart_instruction_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_WORDS      = 8,
  parameter int LITTLE_ENDIAN  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_instruction_assembler_if.slave  bus
);
  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_WORDS);
  localparam logic               LE      = (LITTLE_ENDIAN != 0);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] shift_q, instr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COUNT_W-1:0] count_q;
  logic               dr_q, terr_q, oerr_q;
  logic               accept_byte, complete, timeout_hit, expired;
  logic               busy, debug_flag;

  // EMIT already holds the incremented count, so a full count there blocks input.
  assign accept_byte = bus.i_rx_valid && !bus.i_clear &&
                       ((state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                        ((state_q == ST_EMIT) && (count_q != MAX_CNT)));
  assign complete    = accept_byte && (state_q == ST_COLLECT) && (idx_q == 2'd3);
  assign timeout_hit = expired && (state_q == ST_COLLECT) && !bus.i_clear;

  uart_instruction_assembler_byte_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .restart (accept_byte || bus.i_clear),
    .enable  (state_q == ST_COLLECT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.i_rx_valid) state_d = ST_COLLECT;
        ST_COLLECT: begin
          if (complete)         state_d = ST_EMIT;
          else if (timeout_hit) state_d = ST_IDLE;
        end
        ST_EMIT: begin
          if (count_q == MAX_CNT)    state_d = ST_FULL;
          else if (bus.i_rx_valid)   state_d = ST_COLLECT;
          else                       state_d = ST_IDLE;
        end
        ST_FULL:    state_d = ST_FULL;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == ST_COLLECT);
    debug_flag = (state_q == ST_EMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      instr_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      dr_q    <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else if (bus.i_clear) begin
      shift_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      dr_q    <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      dr_q <= complete;
      if (complete) begin
        instr_q <= insert_byte(shift_q, idx_q, bus.i_rx_byte, LE);
        shift_q <= '0;
        idx_q   <= '0;
        count_q <= count_q + 1'b1;
      end else if (accept_byte) begin
        // A byte outside COLLECT starts a fresh word, discarding stale lanes.
        shift_q <= insert_byte((state_q == ST_COLLECT) ? shift_q : '0,
                               idx_q, bus.i_rx_byte, LE);
        idx_q   <= idx_q + 1'b1;
      end else if (timeout_hit) begin
        shift_q <= '0;
        idx_q   <= '0;
        terr_q  <= 1'b1;
      end
      if ((state_q == ST_FULL) && bus.i_rx_valid) oerr_q <= 1'b1;
    end
  end

  assign bus.o_instruction   = instr_q;
  assign bus.o_data_received = dr_q;
  assign bus.o_word_count    = count_q;
  assign bus.o_busy          = busy;
  assign bus.o_timeout_err   = terr_q;
  assign bus.o_overflow_err  = oerr_q;
  assign bus.o_debug_flag    = debug_flag;
  assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_uart_instruction_assembler.sv
// Directed checks of the instruction assembler: little-endian DUT with a short
// timeout, plus a big-endian instance for byte ordering.
module tb_uart_instruction_assembler;
  import uart_instruction_assembler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;
  int   strobes_le = 0;
  logic prev_dr    = 1'b0;

  uart_instruction_assembler_if le_if ();
  uart_instruction_assembler_if be_if ();

  uart_instruction_assembler #(.TIMEOUT_CYCLES(16), .MAX_WORDS(8), .LITTLE_ENDIAN(1)) dut_le (
    .clk (clk), .rst (rst), .bus (le_if.slave));
  uart_instruction_assembler #(.TIMEOUT_CYCLES(16), .MAX_WORDS(8), .LITTLE_ENDIAN(0)) dut_be (
    .clk (clk), .rst (rst), .bus (be_if.slave));

  always #5 clk = ~clk;

  // Strobe monitor: counts strobes and never allows two in a row.
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if (prev_dr && le_if.o_data_received) begin
        miscompares++;
        $display("FAIL strobe_width got two consecutive cycles want one");
      end
      if (le_if.o_data_received) strobes_le++;
    end
    prev_dr = le_if.o_data_received;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_le(input logic [7:0] b);
    le_if.i_rx_byte  = b;
    le_if.i_rx_valid = 1'b1;
    tick();
    le_if.i_rx_valid = 1'b0;
  endtask

  task automatic push_be(input logic [7:0] b);
    be_if.i_rx_byte  = b;
    be_if.i_rx_valid = 1'b1;
    tick();
    be_if.i_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if (le_if.o_instruction !== 32'h0 || le_if.o_data_received !== 1'b0 ||
        le_if.o_word_count !== 4'd0 || le_if.o_busy !== 1'b0 ||
        le_if.o_timeout_err !== 1'b0 || le_if.o_overflow_err !== 1'b0 ||
        le_if.o_debug_flag !== 1'b0 || le_if.dbg_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_outputs got instr=%h dr=%b cnt=%0d busy=%b terr=%b oerr=%b dbg=%b want all zero",
               le_if.o_instruction, le_if.o_data_received, le_if.o_word_count, le_if.o_busy,
               le_if.o_timeout_err, le_if.o_overflow_err, le_if.o_debug_flag);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_word();
    push_le(8'h33); tick();
    push_le(8'h02); tick();
    push_le(8'h21); tick();
    vectors++;
    if (le_if.o_data_received !== 1'b0 || le_if.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_partial got dr=%b busy=%b want dr=0 busy=1", le_if.o_data_received, le_if.o_busy);
    end
    push_le(8'h00);
    vectors++;
    if (le_if.o_instruction !== 32'h00210233 || le_if.o_data_received !== 1'b1 ||
        le_if.o_word_count !== 4'd1 || le_if.o_debug_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_word got instr=%h dr=%b cnt=%0d dbg=%b want 00210233 1 1 1",
               le_if.o_instruction, le_if.o_data_received, le_if.o_word_count, le_if.o_debug_flag);
    end
    tick();
    vectors++;
    if (le_if.o_data_received !== 1'b0 || le_if.o_instruction !== 32'h00210233 || strobes_le != 1) begin
      miscompares++;
      $display("FAIL basic_after got dr=%b instr=%h strobes=%0d want 0 00210233 1",
               le_if.o_data_received, le_if.o_instruction, strobes_le);
    end
  endtask

  task automatic test_back_to_back();
    push_le(8'h93); push_le(8'h82); push_le(8'h20); push_le(8'h00);
    vectors++;
    if (le_if.o_instruction !== 32'h00208293 || le_if.o_data_received !== 1'b1 || le_if.o_word_count !== 4'd2) begin
      miscompares++;
      $display("FAIL b2b_word got instr=%h dr=%b cnt=%0d want 00208293 1 2",
               le_if.o_instruction, le_if.o_data_received, le_if.o_word_count);
    end
    push_le(8'hAA);
    vectors++;
    if (le_if.o_busy !== 1'b1 || le_if.o_data_received !== 1'b0 || le_if.dbg_state !== ST_COLLECT) begin
      miscompares++;
      $display("FAIL b2b_emit_byte got busy=%b dr=%b state=%0d want 1 0 1",
               le_if.o_busy, le_if.o_data_received, le_if.dbg_state);
    end
    push_le(8'hBB); push_le(8'hCC); push_le(8'hDD);
    vectors++;
    if (le_if.o_instruction !== 32'hDDCCBBAA || le_if.o_data_received !== 1'b1 || le_if.o_word_count !== 4'd3) begin
      miscompares++;
      $display("FAIL b2b_next_word got instr=%h dr=%b cnt=%0d want ddccbbaa 1 3",
               le_if.o_instruction, le_if.o_data_received, le_if.o_word_count);
    end
    tick();
  endtask

  task automatic test_timeout();
    int s0;
    s0 = strobes_le;
    push_le(8'h11);
    push_le(8'h22);
    repeat (15) tick();
    vectors++;
    if (le_if.o_busy !== 1'b1 || le_if.o_timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early got busy=%b terr=%b want 1 0", le_if.o_busy, le_if.o_timeout_err);
    end
    tick();
    vectors++;
    if (le_if.o_busy !== 1'b0 || le_if.o_timeout_err !== 1'b1 || strobes_le != s0 ||
        le_if.o_instruction !== 32'hDDCCBBAA) begin
      miscompares++;
      $display("FAIL timeout_hit got busy=%b terr=%b strobes=%0d instr=%h want 0 1 %0d ddccbbaa",
               le_if.o_busy, le_if.o_timeout_err, strobes_le, le_if.o_instruction, s0);
    end
    push_le(8'h13); push_le(8'h05); push_le(8'h10); push_le(8'h00);
    vectors++;
    if (le_if.o_instruction !== 32'h00100513 || le_if.o_word_count !== 4'd4 || le_if.o_timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recover got instr=%h cnt=%0d terr=%b want 00100513 4 1",
               le_if.o_instruction, le_if.o_word_count, le_if.o_timeout_err);
    end
    tick();
  endtask

  task automatic test_full_and_clear();
    logic [7:0]  b [4];
    logic [31:0] exp_w;
    int          s0;
    s0 = strobes_le;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'(8'h40 + 16 * w + k);
      exp_w = {b[3], b[2], b[1], b[0]};
      for (int k = 0; k < 4; k++) push_le(b[k]);
      vectors++;
      if (le_if.o_instruction !== exp_w || le_if.o_data_received !== 1'b1 ||
          le_if.o_word_count !== 4'(5 + w)) begin
        miscompares++;
        $display("FAIL fill_word%0d got instr=%h dr=%b cnt=%0d want %h 1 %0d",
                 w, le_if.o_instruction, le_if.o_data_received, le_if.o_word_count, exp_w, 5 + w);
      end
      tick();
    end
    vectors++;
    if (le_if.dbg_state !== ST_FULL || le_if.o_overflow_err !== 1'b0 || strobes_le != s0 + 4) begin
      miscompares++;
      $display("FAIL full_state got state=%0d oerr=%b strobes=%0d want 3 0 %0d",
               le_if.dbg_state, le_if.o_overflow_err, strobes_le, s0 + 4);
    end
    push_le(8'hEE); tick();
    vectors++;
    if (le_if.o_overflow_err !== 1'b1 || le_if.o_word_count !== 4'd8 || strobes_le != s0 + 4 ||
        le_if.o_instruction !== 32'h73727170) begin
      miscompares++;
      $display("FAIL overflow got oerr=%b cnt=%0d strobes=%0d instr=%h want 1 8 %0d 73727170",
               le_if.o_overflow_err, le_if.o_word_count, strobes_le, le_if.o_instruction, s0 + 4);
    end
    le_if.i_clear = 1'b1; tick(); le_if.i_clear = 1'b0;
    vectors++;
    if (le_if.o_word_count !== 4'd0 || le_if.o_overflow_err !== 1'b0 || le_if.o_timeout_err !== 1'b0 ||
        le_if.dbg_state !== ST_IDLE || le_if.o_instruction !== 32'h73727170) begin
      miscompares++;
      $display("FAIL clear got cnt=%0d oerr=%b terr=%b state=%0d instr=%h want 0 0 0 0 73727170",
               le_if.o_word_count, le_if.o_overflow_err, le_if.o_timeout_err, le_if.dbg_state, le_if.o_instruction);
    end
    push_le(8'hB7); push_le(8'h02); push_le(8'h00); push_le(8'h80);
    vectors++;
    if (le_if.o_instruction !== 32'h800002B7 || le_if.o_word_count !== 4'd1) begin
      miscompares++;
      $display("FAIL after_clear got instr=%h cnt=%0d want 800002b7 1", le_if.o_instruction, le_if.o_word_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    push_le(8'hFF); push_le(8'hEE); push_le(8'hDD);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (le_if.o_instruction !== 32'h0 || le_if.o_word_count !== 4'd0 || le_if.o_busy !== 1'b0 ||
        le_if.o_data_received !== 1'b0 || le_if.o_debug_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got instr=%h cnt=%0d busy=%b dr=%b dbg=%b want all zero",
               le_if.o_instruction, le_if.o_word_count, le_if.o_busy, le_if.o_data_received, le_if.o_debug_flag);
    end
    tick();
    rst = 1'b1;
    tick();
    push_le(8'h37); push_le(8'h01); push_le(8'h00); push_le(8'h00);
    vectors++;
    if (le_if.o_instruction !== 32'h00000137 || le_if.o_word_count !== 4'd1 || le_if.o_data_received !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_word got instr=%h cnt=%0d dr=%b want 00000137 1 1",
               le_if.o_instruction, le_if.o_word_count, le_if.o_data_received);
    end
    tick();
  endtask

  task automatic test_clear_collision();
    push_le(8'h55); push_le(8'h66);
    le_if.i_rx_byte = 8'h77; le_if.i_rx_valid = 1'b1; le_if.i_clear = 1'b1;
    tick();
    le_if.i_rx_valid = 1'b0; le_if.i_clear = 1'b0;
    vectors++;
    if (le_if.o_busy !== 1'b0 || le_if.dbg_state !== ST_IDLE || le_if.o_word_count !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_collision got busy=%b state=%0d cnt=%0d want 0 0 0",
               le_if.o_busy, le_if.dbg_state, le_if.o_word_count);
    end
    push_le(8'h01); push_le(8'h02); push_le(8'h03); push_le(8'h04);
    vectors++;
    if (le_if.o_instruction !== 32'h04030201 || le_if.o_word_count !== 4'd1) begin
      miscompares++;
      $display("FAIL clear_collision_word got instr=%h cnt=%0d want 04030201 1",
               le_if.o_instruction, le_if.o_word_count);
    end
    tick();
  endtask

  task automatic test_big_endian();
    push_be(8'h00); push_be(8'h21); push_be(8'h02); push_be(8'h33);
    vectors++;
    if (be_if.o_instruction !== 32'h00210233 || be_if.o_data_received !== 1'b1 || be_if.o_word_count !== 4'd1) begin
      miscompares++;
      $display("FAIL big_endian got instr=%h dr=%b cnt=%0d want 00210233 1 1",
               be_if.o_instruction, be_if.o_data_received, be_if.o_word_count);
    end
    tick();
  endtask

  initial begin
    le_if.i_rx_byte = 8'h0; le_if.i_rx_valid = 1'b0; le_if.i_clear = 1'b0;
    be_if.i_rx_byte = 8'h0; be_if.i_rx_valid = 1'b0; be_if.i_clear = 1'b0;
    test_reset();
    test_basic_word();
    test_back_to_back();
    test_timeout();
    test_full_and_clear();
    test_reset_mid_word();
    test_clear_collision();
    test_big_endian();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
